ifetch_unit: RTL
================

Name: ifetch_unit

Overview:
- Instruction-fetch reader that sits between the pc register and instruction memory.
- Takes the current pc and runs a request/grant/response transaction to imem.
- Presents the returned word to decode with a valid/ready handshake.
- Holds the pc register (pc_stall) until the instruction is consumed; detects misaligned pc, bus errors and timeouts as a sticky fault.

Parameters:
- TIMEOUT_CYCLES, 16: maximum cycles allowed from request issue to response; must be at least 2.
- NOP_INSTR, 32'h0000_0013: value driven on instr whenever instr_valid=0.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- pc  in  32  current pc from the pc register
- fetch_en  in  1  permits a new fetch to start
- imem_req  out  1  request strobe to instruction memory
- imem_addr  out  32  word-aligned fetch address
- imem_gnt  in  1  imem accepts the request
- imem_rvalid  in  1  response valid
- imem_rdata  in  32  response data
- imem_err  in  1  response error; qualified by imem_rvalid
- instr  out  32  fetched instruction
- instr_pc  out  32  address of instr
- instr_valid  out  1  instr and instr_pc are valid
- instr_ready  in  1  decode accepts the instruction
- pc_stall  out  1  1 = pc register must hold its value
- fault  out  1  sticky fault flag
- fault_cause  out  2  0 none, 1 misaligned, 2 bus error, 3 timeout
- fault_clr  in  1  clears the fault and returns the block to IDLE

Behaviour:
- Reset (rst=1 at posedge):
  - state=IDLE; imem_req=0, imem_addr=0.
  - instr=NOP_INSTR, instr_pc=0, instr_valid=0.
  - fault=0, fault_cause=0, timeout counter=0.
  - Reset overrides all states, including mid-transaction. The imem side shares rst, so no stale response can arrive after reset.
- pc_stall = NOT (state==HOLD AND instr_ready). The pc advances only on the edge where decode accepts the instruction.
- IDLE:
  - fetch_en=1 and pc[1:0]!=0 -> FAULT with cause 1.
  - fetch_en=1 and pc aligned -> REQ; addr_q<=pc, counter<=0.
  - fetch_en=0 -> stay in IDLE.
- REQ:
  - imem_req=1, imem_addr=addr_q, both stable until grant.
  - imem_gnt=1 -> WAIT.
  - imem_rvalid is never sampled in REQ; the response comes no earlier than the cycle after the grant.
- WAIT:
  - imem_req=0.
  - imem_rvalid=1 and imem_err=1 -> FAULT with cause 2.
  - imem_rvalid=1 and imem_err=0 -> instr<=imem_rdata, instr_pc<=addr_q, instr_valid<=1, go to HOLD.
- Timeout:
  - The counter increments on every cycle spent in REQ or WAIT; width $clog2(TIMEOUT_CYCLES+1).
  - If the counter equals TIMEOUT_CYCLES-1 and no gnt (in REQ) or rvalid (in WAIT) occurs that cycle -> FAULT with cause 3.
  - A completion event in the same cycle as the timeout wins.
- HOLD:
  - instr_valid=1; instr and instr_pc stay stable.
  - instr_ready=1 -> instr_valid<=0, instr<=NOP_INSTR, go to IDLE.
  - The pc register loads next_pc on that same edge, so IDLE sees the new pc on the next cycle.
- FAULT:
  - fault=1 and fault_cause held; imem_req=0, instr_valid=0, pc_stall=1.
  - fault_clr=1 -> fault<=0, fault_cause<=0, go to IDLE. fault_clr is ignored in every other state.
- Latency and throughput:
  - Best case (gnt in the first REQ cycle, rvalid in the first WAIT cycle): instr_valid rises 3 cycles after IDLE sees fetch_en.
  - Minimum 4 cycles per instruction with instr_ready tied to 1.
- Arithmetic: no pc arithmetic inside this block. imem_addr is the full 32-bit addr_q with bits [1:0] guaranteed to be 0.

Decomposition:
- Package rv_fetch_pkg holds:
  - fetch_state_t enum {IDLE, REQ, WAIT, HOLD, FAULT}
  - fault_cause_t enum {FC_NONE=2'd0, FC_MISALIGN=2'd1, FC_BUS_ERR=2'd2, FC_TIMEOUT=2'd3}
  - localparam RV_NOP = 32'h0000_0013
- One sub-module, fetch_timeout_ctr: parameter TIMEOUT_CYCLES; inputs clr and en; output expire, asserted when count==TIMEOUT_CYCLES-1 and en=1.

Test Plan:
- Basic fetch: pc=0x0000_0000, fetch_en=1, gnt on the first REQ cycle, rvalid the next cycle with rdata=0x0000_0093, instr_ready=1 -> imem_addr=0x0 while imem_req=1; instr=0x0000_0093, instr_pc=0x0 with instr_valid=1 exactly 3 cycles after fetch_en; pc_stall=0 for exactly one cycle.
- Backpressure: same fetch with instr_ready=0 for 5 cycles -> instr_valid, instr and instr_pc stable and pc_stall=1 throughout; release -> IDLE; next pc=0x4 fetched.
- Misaligned: pc=0x0000_0006, fetch_en=1 -> fault=1, cause=1 next cycle; imem_req never asserted; fault_clr=1 -> fault=0, state IDLE.
- Bus error: rvalid=1 with imem_err=1 at pc=0x10 -> fault=1, cause=2, instr_valid stays 0.
- Timeouts, TIMEOUT_CYCLES=4:
  - gnt never asserted -> fault with cause=3 after 4 REQ cycles.
  - gnt and rvalid both land on the expiry cycle -> no fault; the instruction is delivered.
- Reset mid-operation: assert rst while in WAIT at pc=0x8 -> next cycle all outputs at reset values, state IDLE; a fresh fetch of 0x8 then completes normally.

Source files
------------

// File: rtl/ifetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch unit.
// Holds the fetch FSM encoding, fault cause codes and the canonical NOP.
package rv_fetch_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD,
        FAULT
    } fetch_state_t;

    typedef enum logic [1:0] {
        FC_NONE     = 2'd0,
        FC_MISALIGN = 2'd1,
        FC_BUS_ERR  = 2'd2,
        FC_TIMEOUT  = 2'd3
    } fault_cause_t;

    localparam logic [31:0] RV_NOP = 32'h0000_0013;

endpackage

// File: rtl/ifetch_unit_if.sv
// Request/grant/response bus between the fetch unit (master) and instruction memory (slave).
interface ifetch_unit_if;

    logic        req;
    logic [31:0] addr;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;

    modport master (
        output req,
        output addr,
        input  gnt,
        input  rvalid,
        input  rdata,
        input  err
    );

    modport slave (
        input  req,
        input  addr,
        output gnt,
        output rvalid,
        output rdata,
        output err
    );

endinterface

// File: rtl/ifetch_unit_timeout_ctr.sv
// Counts cycles while a memory transaction is outstanding and flags the last allowed cycle.
module fetch_timeout_ctr #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + W'(1);
        end
    end

    assign expire = en && (count == LAST);

endmodule

// File: rtl/ifetch_unit.sv
// Instruction-fetch reader: issues one imem transaction per pc, hands the word to decode,
// and latches misalignment, bus errors and timeouts as a sticky fault.
module ifetch_unit
    import rv_fetch_pkg::*;
#(
    parameter int          TIMEOUT_CYCLES = 16,
    parameter logic [31:0] NOP_INSTR      = RV_NOP
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [31:0]         pc,
    input  logic                fetch_en,
    ifetch_unit_if.master       imem,
    output logic [31:0]         instr,
    output logic [31:0]         instr_pc,
    output logic                instr_valid,
    input  logic                instr_ready,
    output logic                pc_stall,
    output logic                fault,
    output logic [1:0]          fault_cause,
    input  logic                fault_clr
);

    fetch_state_t state, state_next;
    fault_cause_t cause_q, cause_next;

    logic [31:0] addr_q;
    logic        load_addr;
    logic        deliver;
    logic        consume;
    logic        set_fault;
    logic        clear_fault;
    logic        busy;
    logic        expire;

    assign busy = (state == REQ) || (state == WAIT);

    fetch_timeout_ctr #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .clr    (!busy),
        .en     (busy),
        .expire (expire)
    );

    // Completion events (gnt in REQ, rvalid in WAIT) are checked before expire so they win a tie.
    always_comb begin
        state_next  = state;
        cause_next  = FC_NONE;
        load_addr   = 1'b0;
        deliver     = 1'b0;
        consume     = 1'b0;
        set_fault   = 1'b0;
        clear_fault = 1'b0;
        case (state)
            IDLE: begin
                if (fetch_en) begin
                    if (pc[1:0] != 2'b00) begin
                        state_next = FAULT;
                        set_fault  = 1'b1;
                        cause_next = FC_MISALIGN;
                    end else begin
                        state_next = REQ;
                        load_addr  = 1'b1;
                    end
                end
            end
            REQ: begin
                if (imem.gnt) begin
                    state_next = WAIT;
                end else if (expire) begin
                    state_next = FAULT;
                    set_fault  = 1'b1;
                    cause_next = FC_TIMEOUT;
                end
            end
            WAIT: begin
                if (imem.rvalid) begin
                    if (imem.err) begin
                        state_next = FAULT;
                        set_fault  = 1'b1;
                        cause_next = FC_BUS_ERR;
                    end else begin
                        state_next = HOLD;
                        deliver    = 1'b1;
                    end
                end else if (expire) begin
                    state_next = FAULT;
                    set_fault  = 1'b1;
                    cause_next = FC_TIMEOUT;
                end
            end
            HOLD: begin
                if (instr_ready) begin
                    state_next = IDLE;
                    consume    = 1'b1;
                end
            end
            FAULT: begin
                if (fault_clr) begin
                    state_next  = IDLE;
                    clear_fault = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            addr_q      <= '0;
            instr       <= NOP_INSTR;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
            fault       <= 1'b0;
            cause_q     <= FC_NONE;
        end else begin
            state <= state_next;
            if (load_addr) begin
                addr_q <= {pc[31:2], 2'b00};
            end
            if (deliver) begin
                instr       <= imem.rdata;
                instr_pc    <= addr_q;
                instr_valid <= 1'b1;
            end
            if (consume) begin
                instr       <= NOP_INSTR;
                instr_valid <= 1'b0;
            end
            if (set_fault) begin
                fault   <= 1'b1;
                cause_q <= cause_next;
            end
            if (clear_fault) begin
                fault   <= 1'b0;
                cause_q <= FC_NONE;
            end
        end
    end

    assign imem.req    = (state == REQ);
    assign imem.addr   = addr_q;
    assign fault_cause = cause_q;
    // The pc register may only advance on the edge where decode takes the instruction.
    assign pc_stall    = !((state == HOLD) && instr_ready);

endmodule
